analog_rx_sched: RTL and testbench

//  Buffered, FSM-driven successor RX stage between the digital spin engine and the analog Ising macro.
//  - Accepts spin vectors over valid/ready into an internal FIFO.
//  - Per vector, runs one job: WRITE phase (drive WWL/WBL), COMPUTE phase (drive compute enables),

---
 rtl/analog_rx_pkg.sv | 25 ++
 rtl/analog_rx_spin_fifo.sv | 54 +++++
 rtl/analog_rx_sched.sv | 194 +++++++++++++++++++
 tb/tb_analog_rx_sched.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/analog_rx_pkg.sv
// Shared types for the analog RX scheduler: FSM state encoding, config layout, job counter width.
// Pure type/constant package: no latency, no flow control.
// Backpressure: not applicable.
package analog_rx_pkg;

    localparam int JOB_CNT_W   = 16;
    localparam int RX_NUM_SPIN = 256;
    localparam int RX_CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        COMPUTE   = 2'd2,
        WAIT_IDLE = 2'd3
    } rx_state_e;

    // Default-width config layout; the scheduler mirrors these fields at its own widths.
    typedef struct packed {
        logic [RX_CNT_W-1:0]    write_cyc;
        logic [RX_CNT_W-1:0]    cmpt_cyc;
        logic [RX_NUM_SPIN-1:0] wwl_strobe;
        logic [RX_NUM_SPIN-1:0] mode;
    } rx_cfg_t;

endpackage

// File: rtl/analog_rx_spin_fifo.sv
// Spin-vector FIFO with occupancy output and registered ready.
// Latency: a pushed entry is visible at the head one cycle later (no fall-through).
// Backpressure: ready_o = !full, registered; a push while full is dropped even if a pop occurs.
module analog_rx_spin_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q, level_d;
    logic             ready_q;
    logic             push_ok, pop_ok;

    assign empty_o = (level_q == '0);
    assign push_ok = push_i & ready_q;
    assign pop_ok  = pop_i & ~empty_o;
    assign level_d = level_q + LW'(push_ok) - LW'(pop_ok);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
            ready_q <= (level_d != LW'(DEPTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign ready_o = ready_q;
    assign level_o = level_q;

endmodule

// File: rtl/analog_rx_sched.sv
// Buffered RX scheduler: per queued spin vector runs WRITE, COMPUTE, then waits for macro idle.
// Latency: first WWL cycle is the cycle after the pop; all macro-facing outputs registered.
// Backpressure: spin_ready_o drops when FIFO full; optional watchdog via ANALOG_RX_TIMEOUT_EN.
module analog_rx_sched
    import analog_rx_pkg::*;
#(
    parameter int NUM_SPIN       = 256,
    parameter int CNT_W          = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 cfg_load_i,
    input  logic [CNT_W-1:0]     cfg_write_cyc_i,
    input  logic [CNT_W-1:0]     cfg_cmpt_cyc_i,
    input  logic [NUM_SPIN-1:0]  cfg_wwl_strobe_i,
    input  logic [NUM_SPIN-1:0]  cfg_mode_i,
    input  logic                 spin_valid_i,
    output logic                 spin_ready_o,
    input  logic [NUM_SPIN-1:0]  spin_i,
    input  logic                 analog_macro_idle_i,
    output logic [NUM_SPIN-1:0]  spin_wwl_o,
    output logic [NUM_SPIN-1:0]  wbl_o,
    output logic [NUM_SPIN-1:0]  spin_compute_en_o,
    output logic [LVL_W-1:0]     fifo_level_o,
    output logic                 rx_idle_o,
    output logic                 cmpt_done_o,
    output logic [JOB_CNT_W-1:0] job_cnt_o,
    output logic                 timeout_err_o
);

    typedef struct packed {
        logic [CNT_W-1:0]    write_cyc;
        logic [CNT_W-1:0]    cmpt_cyc;
        logic [NUM_SPIN-1:0] wwl_strobe;
        logic [NUM_SPIN-1:0] mode;
    } cfg_t;

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    cfg_t                 cfg_q, cfg_d;
    logic [NUM_SPIN-1:0]  wwl_q, wwl_d;
    logic [NUM_SPIN-1:0]  wbl_q, wbl_d;
    logic [NUM_SPIN-1:0]  cen_q, cen_d;
    logic                 done_q, done_d;
    logic [JOB_CNT_W-1:0] job_q, job_d;
    logic                 terr_q, terr_d;

    logic                 pop;
    logic                 fifo_empty;
    logic [NUM_SPIN-1:0]  fifo_head;
    logic                 phase_last;
    logic                 wd_hit;
    logic                 cfg_take;

    analog_rx_spin_fifo #(
        .WIDTH (NUM_SPIN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (spin_valid_i),
        .data_i  (spin_i),
        .ready_o (spin_ready_o),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    // A phase of length 0 or 1 both end after their first cycle.
    assign phase_last = (cnt_q <= CNT_W'(1));
    assign cfg_take   = cfg_load_i & (state_q == IDLE);

`ifdef ANALOG_RX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;

    assign wd_hit = (state_q == WAIT_IDLE) & (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign wd_d   = ((state_q == WAIT_IDLE) && (state_d == WAIT_IDLE)) ? wd_q + WD_W'(1) : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) wd_q <= '0;
        else       wd_q <= wd_d;
    end

    always_comb begin
        terr_d = terr_q;
        if (!en_i || cfg_take)                         terr_d = 1'b0;
        else if (wd_hit && !analog_macro_idle_i)       terr_d = 1'b1;
    end
`else
    assign wd_hit = 1'b0;
    assign terr_d = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        if (!en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty && analog_macro_idle_i) begin
                        pop     = 1'b1;
                        state_d = WRITE;
                        cnt_d   = cfg_q.write_cyc;
                    end
                end
                WRITE: begin
                    if (phase_last) begin
                        state_d = COMPUTE;
                        cnt_d   = cfg_q.cmpt_cyc;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                COMPUTE: begin
                    if (phase_last) state_d = WAIT_IDLE;
                    else            cnt_d   = cnt_q - CNT_W'(1);
                end
                WAIT_IDLE: begin
                    if (analog_macro_idle_i || wd_hit) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are computed from the next state so the registered copy lines up with state_q.
    always_comb begin
        wwl_d  = (state_d == WRITE)   ? cfg_q.wwl_strobe : '0;
        cen_d  = (state_d == COMPUTE) ? cfg_q.mode       : '0;
        wbl_d  = pop ? fifo_head : wbl_q;
        cfg_d  = cfg_q;
        done_d = done_q;
        job_d  = job_q;
        if (cfg_take) begin
            cfg_d.write_cyc  = cfg_write_cyc_i;
            cfg_d.cmpt_cyc   = cfg_cmpt_cyc_i;
            cfg_d.wwl_strobe = cfg_wwl_strobe_i;
            cfg_d.mode       = cfg_mode_i;
        end
        if (!en_i) begin
            done_d = 1'b0;
        end else if (pop) begin
            done_d = 1'b0;
        end else if (state_q == COMPUTE && state_d == WAIT_IDLE) begin
            done_d = 1'b1;
            job_d  = job_q + JOB_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            cfg_q  <= '0;
            wwl_q  <= '0;
            wbl_q  <= '0;
            cen_q  <= '0;
            done_q <= 1'b0;
            job_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            cfg_q  <= cfg_d;
            wwl_q  <= wwl_d;
            wbl_q  <= wbl_d;
            cen_q  <= cen_d;
            done_q <= done_d;
            job_q  <= job_d;
            terr_q <= terr_d;
        end
    end

    assign spin_wwl_o        = wwl_q;
    assign wbl_o             = wbl_q;
    assign spin_compute_en_o = cen_q;
    assign cmpt_done_o       = done_q;
    assign job_cnt_o         = job_q;
    assign timeout_err_o     = terr_q;
    assign rx_idle_o         = (state_q == IDLE) & fifo_empty;

endmodule

// File: tb/tb_analog_rx_sched.sv
// Directed-plus-random bench for analog_rx_sched against a job-level reference model.
module tb_analog_rx_sched;

    localparam int NS = 32;
    localparam int CW = 8;
    localparam int FD = 4;
    localparam int TO = 16;
    localparam int LW = $clog2(FD) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          cfg_load;
    logic [CW-1:0] cfg_w, cfg_c;
    logic [NS-1:0] cfg_s, cfg_m;
    logic          spin_valid;
    logic          spin_ready;
    logic [NS-1:0] spin;
    logic          macro_idle;
    logic [NS-1:0] wwl, wbl, cen;
    logic [LW-1:0] level;
    logic          rx_idle, done, terr;
    logic [15:0]   job_cnt;

    always #5 clk = ~clk;

    analog_rx_sched #(
        .NUM_SPIN       (NS),
        .CNT_W          (CW),
        .FIFO_DEPTH     (FD),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .en_i                (en),
        .cfg_load_i          (cfg_load),
        .cfg_write_cyc_i     (cfg_w),
        .cfg_cmpt_cyc_i      (cfg_c),
        .cfg_wwl_strobe_i    (cfg_s),
        .cfg_mode_i          (cfg_m),
        .spin_valid_i        (spin_valid),
        .spin_ready_o        (spin_ready),
        .spin_i              (spin),
        .analog_macro_idle_i (macro_idle),
        .spin_wwl_o          (wwl),
        .wbl_o               (wbl),
        .spin_compute_en_o   (cen),
        .fifo_level_o        (level),
        .rx_idle_o           (rx_idle),
        .cmpt_done_o         (done),
        .job_cnt_o           (job_cnt),
        .timeout_err_o       (terr)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: queued vectors, active config and completed job count.
    logic [NS-1:0] q[$];
    int            m_w, m_c;
    logic [NS-1:0] m_s, m_m;
    int            m_jobs = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_cfg(input int w, input int c, input logic [NS-1:0] s, input logic [NS-1:0] m);
        cfg_w = CW'(w); cfg_c = CW'(c); cfg_s = s; cfg_m = m;
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        m_w = w; m_c = c; m_s = s; m_m = m;
    endtask

    task automatic push(input logic [NS-1:0] v, input bit accept);
        spin_valid = 1'b1;
        spin       = v;
        chk("push_ready", 64'(spin_ready), 64'(accept));
        @(negedge clk);
        spin_valid = 1'b0;
        if (accept) q.push_back(v);
    endtask

    // Called at a negedge where the FSM is IDLE with a poppable head; the pop is the next edge.
    task automatic do_job();
        logic [NS-1:0] v;
        int w, c;
        v = q.pop_front();
        w = (m_w < 1) ? 1 : m_w;
        c = (m_c < 1) ? 1 : m_c;
        for (int i = 0; i < w; i++) begin
            @(negedge clk);
            chk("write_wwl", 64'(wwl), 64'(m_s));
            chk("write_wbl", 64'(wbl), 64'(v));
            chk("write_cen", 64'(cen), 64'(0));
            chk("write_done", 64'(done), 64'(0));
            if (i == 0) chk("pop_level", 64'(level), 64'(q.size()));
        end
        for (int i = 0; i < c; i++) begin
            @(negedge clk);
            chk("cmpt_wwl", 64'(wwl), 64'(0));
            chk("cmpt_cen", 64'(cen), 64'(m_m));
            chk("cmpt_jobs", 64'(job_cnt), 64'(m_jobs[15:0]));
        end
        @(negedge clk);
        m_jobs++;
        chk("wait_wwl", 64'(wwl), 64'(0));
        chk("wait_cen", 64'(cen), 64'(0));
        chk("wait_wbl", 64'(wbl), 64'(v));
        chk("wait_done", 64'(done), 64'(1));
        chk("wait_jobs", 64'(job_cnt), 64'(m_jobs[15:0]));
    endtask

    initial begin
        logic [NS-1:0] v1, v2;
        int busy_len;

        rst = 1'b1; en = 1'b0; cfg_load = 1'b0; cfg_w = '0; cfg_c = '0; cfg_s = '0; cfg_m = '0;
        spin_valid = 1'b0; spin = '0; macro_idle = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(spin_ready), 64'(1));
        chk("rst_rx_idle", 64'(rx_idle), 64'(1));
        chk("rst_wwl", 64'(wwl), 64'(0));
        chk("rst_wbl", 64'(wbl), 64'(0));
        chk("rst_cen", 64'(cen), 64'(0));
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_jobs", 64'(job_cnt), 64'(0));
        chk("rst_terr", 64'(terr), 64'(0));

        // Single job, write=3 / compute=5.
        macro_idle = 1'b1;
        load_cfg(3, 5, $urandom | 32'h1, $urandom | 32'h1);
        en = 1'b1;
        push(32'hA5A5_A5A5, 1'b1);
        do_job();
        chk("single_job_cnt", 64'(job_cnt), 64'(1));
        @(negedge clk);
        chk("single_rx_idle", 64'(rx_idle), 64'(1));
        chk("single_done_sticky", 64'(done), 64'(1));

        // FIFO full with en low, then drain in push order.
        en = 1'b0;
        for (int i = 0; i < 5; i++) push($urandom, i < FD);
        chk("full_level", 64'(level), 64'(FD));
        chk("full_ready", 64'(spin_ready), 64'(0));
        load_cfg($urandom_range(0, 6), $urandom_range(0, 6), $urandom, $urandom);
        en = 1'b1;
        for (int i = 0; i < FD; i++) begin
            do_job();
            @(negedge clk);
            chk("drain_rx_idle", 64'(rx_idle), 64'(q.size() == 0));
        end

        // Zero-length phases.
        load_cfg(0, 0, $urandom | 32'h1, $urandom | 32'h1);
        push($urandom, 1'b1);
        do_job();
        @(negedge clk);

        // Macro busy after COMPUTE; a config load while busy is ignored.
        en = 1'b0;
        load_cfg($urandom_range(1, 4), $urandom_range(1, 4), $urandom | 32'h1, $urandom | 32'h1);
        v1 = $urandom; v2 = $urandom;
        push(v1, 1'b1);
        push(v2, 1'b1);
        en = 1'b1;
        do_job();
        macro_idle = 1'b0;
`ifdef ANALOG_RX_TIMEOUT_EN
        busy_len = TO - 6;
`else
        busy_len = 20;
`endif
        for (int i = 0; i < busy_len; i++) begin
            @(negedge clk);
            chk("busy_wwl", 64'(wwl), 64'(0));
            chk("busy_cen", 64'(cen), 64'(0));
            chk("busy_level", 64'(level), 64'(1));
            chk("busy_rx_idle", 64'(rx_idle), 64'(0));
            cfg_load = (i == 3);
            cfg_w = 8'd7; cfg_c = 8'd7; cfg_s = ~m_s; cfg_m = ~m_m;
        end
        cfg_load = 1'b0;
        macro_idle = 1'b1;
        @(negedge clk);
        chk("busy_release_level", 64'(level), 64'(1));
        do_job();
        @(negedge clk);

        // Abort on the second WRITE cycle.
        en = 1'b0;
        load_cfg(5, 3, $urandom | 32'h1, $urandom | 32'h1);
        push($urandom, 1'b1);
        push($urandom, 1'b1);
        en = 1'b1;
        @(negedge clk);
        void'(q.pop_front());
        chk("abort_w1_wwl", 64'(wwl), 64'(m_s));
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("abort_wwl", 64'(wwl), 64'(0));
        chk("abort_cen", 64'(cen), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_level", 64'(level), 64'(1));
        chk("abort_jobs", 64'(job_cnt), 64'(m_jobs[15:0]));
        repeat (3) @(negedge clk);
        chk("abort_hold_level", 64'(level), 64'(1));
        en = 1'b1;
        do_job();
        @(negedge clk);

        // Random rounds.
        for (int r = 0; r < 3; r++) begin
            int n;
            en = 1'b0;
            load_cfg($urandom_range(0, 6), $urandom_range(0, 6), $urandom, $urandom);
            n = $urandom_range(1, FD);
            for (int i = 0; i < n; i++) push($urandom, 1'b1);
            en = 1'b1;
            for (int i = 0; i < n; i++) begin
                do_job();
                @(negedge clk);
            end
            chk("rand_rx_idle", 64'(rx_idle), 64'(1));
        end

`ifdef ANALOG_RX_TIMEOUT_EN
        push($urandom, 1'b1);
        do_job();
        macro_idle = 1'b0;
        for (int i = 0; i < TO - 1; i++) begin
            @(negedge clk);
            chk("to_pending", 64'(terr), 64'(0));
            chk("to_rx_idle_wait", 64'(rx_idle), 64'(0));
        end
        @(negedge clk);
        chk("to_err_set", 64'(terr), 64'(1));
        chk("to_rx_idle", 64'(rx_idle), 64'(1));
        load_cfg(m_w, m_c, m_s, m_m);
        chk("to_err_clear", 64'(terr), 64'(0));
        macro_idle = 1'b1;
`else
        chk("terr_tied_low", 64'(terr), 64'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
